jelly2_img_blk_minmax: RTL and testbench

- Downstream consumer of jelly2_img_blk_buffer. Takes its N×M pixel window per cycle and outputs one pixel: per-component minimum (erosion) or maximum (dilation) over the window.
- Implemented as a fixed-latency pipelined comparator tree.
- Passes row/col flags, de, user and valid through, aligned with the data.
- Typical chain: blk_buffer → blk_minmax → slave model / next image stage.

---
 rtl/jelly2_img_minmax_pkg.sv | 46 ++++
 rtl/jelly2_img_minmax_stage.sv | 47 ++++
 rtl/jelly2_img_blk_minmax.sv | 102 ++++++++++
 tb/tb_jelly2_img_blk_minmax.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jelly2_img_minmax_pkg.sv
// Shared types and helpers for the block min/max (erosion/dilation) filter.
// The mode enum, latency rule and per-component pixel compare live here.
package jelly2_img_minmax_pkg;

  typedef enum logic {
    MINMAX_MIN = 1'b0,
    MINMAX_MAX = 1'b1
  } minmax_mode_t;

  // Widest pixel minmax_pixel() can handle; callers zero-extend into it.
  localparam int MINMAX_MAX_WIDTH = 256;

  function automatic minmax_mode_t minmax_mode_from_string(input string s);
    return (s == "MIN") ? MINMAX_MIN : MINMAX_MAX;
  endfunction

  function automatic int calc_latency(input int k);
    return ($clog2(k) < 1) ? 1 : $clog2(k);
  endfunction

  // Unsigned min/max of each component; channels never interact.
  function automatic logic [MINMAX_MAX_WIDTH-1:0] minmax_pixel(
    input logic [MINMAX_MAX_WIDTH-1:0] a,
    input logic [MINMAX_MAX_WIDTH-1:0] b,
    input minmax_mode_t                mode,
    input int                          components,
    input int                          component_width
  );
    logic [MINMAX_MAX_WIDTH-1:0] mask;
    logic [MINMAX_MAX_WIDTH-1:0] ca;
    logic [MINMAX_MAX_WIDTH-1:0] cb;
    logic [MINMAX_MAX_WIDTH-1:0] res;
    mask = (MINMAX_MAX_WIDTH'(1) << component_width) - MINMAX_MAX_WIDTH'(1);
    res  = '0;
    for (int c = 0; c < components; c++) begin
      ca = (a >> (c * component_width)) & mask;
      cb = (b >> (c * component_width)) & mask;
      if ((mode == MINMAX_MAX) ? (cb > ca) : (cb < ca)) begin
        ca = cb;
      end
      res = res | (ca << (c * component_width));
    end
    return res;
  endfunction

endpackage

// File: rtl/jelly2_img_minmax_stage.sv
// One level of the min/max comparator tree: CNT pixels in, ceil(CNT/2)
// registered pixels out. An odd trailing pixel is carried through unchanged.
module jelly2_img_minmax_stage
  import jelly2_img_minmax_pkg::*;
#(
  parameter int           CNT             = 9,
  parameter int           DATA_WIDTH      = 24,
  parameter int           COMPONENTS      = 3,
  parameter int           COMPONENT_WIDTH = 8,
  parameter minmax_mode_t MODE            = MINMAX_MAX,
  localparam int          OUT_CNT         = (CNT + 1) / 2
) (
  input  logic                               reset,
  input  logic                               clk,
  input  logic                               cke,
  input  logic [CNT-1:0][DATA_WIDTH-1:0]     s_data,
  output logic [OUT_CNT-1:0][DATA_WIDTH-1:0] m_data
);

  logic [2*OUT_CNT-1:0][DATA_WIDTH-1:0] pad;
  logic [OUT_CNT-1:0][DATA_WIDTH-1:0]   next_data;

  // Duplicating the odd element makes op(x, x) = x, so it passes unchanged.
  if (CNT % 2 == 1) begin : g_odd
    assign pad = {s_data[CNT-1], s_data};
  end else begin : g_even
    assign pad = s_data;
  end

  always_comb begin
    next_data = '0;
    for (int i = 0; i < OUT_CNT; i++) begin
      next_data[i] = DATA_WIDTH'(minmax_pixel(MINMAX_MAX_WIDTH'(pad[2*i]),
                                              MINMAX_MAX_WIDTH'(pad[2*i+1]),
                                              MODE, COMPONENTS, COMPONENT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_data <= '0;
    end else if (cke) begin
      m_data <= next_data;
    end
  end

endmodule

// File: rtl/jelly2_img_blk_minmax.sv
// N x M window min (erosion) / max (dilation) as a fixed-latency comparator
// tree; position flags, de, user and valid ride a matching delay line.
module jelly2_img_blk_minmax
  import jelly2_img_minmax_pkg::*;
#(
  parameter int    M               = 3,
  parameter int    N               = 3,
  parameter int    COMPONENTS      = 3,
  parameter int    COMPONENT_WIDTH = 8,
  parameter int    DATA_WIDTH      = COMPONENTS * COMPONENT_WIDTH,
  parameter int    USER_WIDTH      = 0,
  parameter string MODE            = "MAX",
  localparam int   USER_BITS       = (USER_WIDTH > 0) ? USER_WIDTH : 1,
  localparam int   LATENCY         = calc_latency(N * M)
) (
  input  logic                                 reset,
  input  logic                                 clk,
  input  logic                                 cke,

  input  logic                                 s_img_row_first,
  input  logic                                 s_img_row_last,
  input  logic                                 s_img_col_first,
  input  logic                                 s_img_col_last,
  input  logic                                 s_img_de,
  input  logic [USER_BITS-1:0]                 s_img_user,
  input  logic [N-1:0][M-1:0][DATA_WIDTH-1:0]  s_img_data,
  input  logic                                 s_img_valid,

  output logic                                 m_img_row_first,
  output logic                                 m_img_row_last,
  output logic                                 m_img_col_first,
  output logic                                 m_img_col_last,
  output logic                                 m_img_de,
  output logic [USER_BITS-1:0]                 m_img_user,
  output logic [DATA_WIDTH-1:0]                m_img_data,
  output logic                                 m_img_valid
);

  localparam int           K        = N * M;
  localparam int           SB_W     = 6 + USER_BITS;
  localparam minmax_mode_t MODE_SEL = minmax_mode_from_string(MODE);

  if (MODE != "MAX" && MODE != "MIN") begin : g_bad_mode
    $error("jelly2_img_blk_minmax: MODE must be \"MAX\" or \"MIN\"");
  end

  // Packed layout already places window element (y, x) at index y*M+x.
  logic [K-1:0][DATA_WIDTH-1:0] flat_data;
  assign flat_data = s_img_data;

  for (genvar l = 0; l < LATENCY; l++) begin : g_lvl
    localparam int IN_CNT  = (K + (1 << l) - 1) >> l;
    localparam int OUT_CNT = (IN_CNT + 1) / 2;

    logic [IN_CNT-1:0][DATA_WIDTH-1:0]  in_data;
    logic [OUT_CNT-1:0][DATA_WIDTH-1:0] out_data;

    if (l == 0) begin : g_first
      assign in_data = flat_data;
    end else begin : g_next
      assign in_data = g_lvl[l-1].out_data;
    end

    jelly2_img_minmax_stage #(
      .CNT             (IN_CNT),
      .DATA_WIDTH      (DATA_WIDTH),
      .COMPONENTS      (COMPONENTS),
      .COMPONENT_WIDTH (COMPONENT_WIDTH),
      .MODE            (MODE_SEL)
    ) u_stage (
      .reset  (reset),
      .clk    (clk),
      .cke    (cke),
      .s_data (in_data),
      .m_data (out_data)
    );
  end

  assign m_img_data = g_lvl[LATENCY-1].out_data[0];

  // Sideband is a plain delay, deliberately not gated by valid or de.
  logic [SB_W-1:0]              sb_in;
  logic [LATENCY-1:0][SB_W-1:0] sb_q;

  assign sb_in = {s_img_row_first, s_img_row_last, s_img_col_first,
                  s_img_col_last, s_img_de, s_img_user, s_img_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
    end else if (cke) begin
      sb_q[0] <= sb_in;
      for (int i = 1; i < LATENCY; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  assign {m_img_row_first, m_img_row_last, m_img_col_first,
          m_img_col_last, m_img_de, m_img_user, m_img_valid} = sb_q[LATENCY-1];

endmodule

// File: tb/tb_jelly2_img_blk_minmax.sv
// Bench for jelly2_img_blk_minmax: four configurations share one stimulus
// stream and are checked against a history-based window reduction model.
module tb_jelly2_img_blk_minmax;

  localparam int LAT33 = 4;  // 3x3 window
  localparam int LAT17 = 3;  // 1x7 column
  localparam int LAT11 = 1;  // 1x1 window

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cke;
  logic rf, rl, cf, cl, de, valid;
  logic [3:0]              user;
  logic [2:0][2:0][23:0]   d33;
  logic [6:0][0:0][7:0]    d17;
  logic [0:0][0:0][23:0]   d11;

  wire [5:0]  max_fl, min_fl, col_fl, one_fl;
  wire [3:0]  max_user, min_user, one_user;
  wire [0:0]  col_user;
  wire [23:0] max_data, min_data, one_data;
  wire [7:0]  col_data;

  int checks = 0;
  int errors = 0;

  jelly2_img_blk_minmax #(.M(3), .N(3), .COMPONENTS(3), .COMPONENT_WIDTH(8),
                          .USER_WIDTH(4), .MODE("MAX")) u_max (
    .reset(reset), .clk(clk), .cke(cke),
    .s_img_row_first(rf), .s_img_row_last(rl), .s_img_col_first(cf), .s_img_col_last(cl),
    .s_img_de(de), .s_img_user(user), .s_img_data(d33), .s_img_valid(valid),
    .m_img_row_first(max_fl[5]), .m_img_row_last(max_fl[4]), .m_img_col_first(max_fl[3]),
    .m_img_col_last(max_fl[2]), .m_img_de(max_fl[1]), .m_img_user(max_user),
    .m_img_data(max_data), .m_img_valid(max_fl[0]));

  jelly2_img_blk_minmax #(.M(3), .N(3), .COMPONENTS(3), .COMPONENT_WIDTH(8),
                          .USER_WIDTH(4), .MODE("MIN")) u_min (
    .reset(reset), .clk(clk), .cke(cke),
    .s_img_row_first(rf), .s_img_row_last(rl), .s_img_col_first(cf), .s_img_col_last(cl),
    .s_img_de(de), .s_img_user(user), .s_img_data(d33), .s_img_valid(valid),
    .m_img_row_first(min_fl[5]), .m_img_row_last(min_fl[4]), .m_img_col_first(min_fl[3]),
    .m_img_col_last(min_fl[2]), .m_img_de(min_fl[1]), .m_img_user(min_user),
    .m_img_data(min_data), .m_img_valid(min_fl[0]));

  jelly2_img_blk_minmax #(.M(1), .N(7), .COMPONENTS(1), .COMPONENT_WIDTH(8),
                          .USER_WIDTH(0), .MODE("MIN")) u_col (
    .reset(reset), .clk(clk), .cke(cke),
    .s_img_row_first(rf), .s_img_row_last(rl), .s_img_col_first(cf), .s_img_col_last(cl),
    .s_img_de(de), .s_img_user(user[0:0]), .s_img_data(d17), .s_img_valid(valid),
    .m_img_row_first(col_fl[5]), .m_img_row_last(col_fl[4]), .m_img_col_first(col_fl[3]),
    .m_img_col_last(col_fl[2]), .m_img_de(col_fl[1]), .m_img_user(col_user),
    .m_img_data(col_data), .m_img_valid(col_fl[0]));

  jelly2_img_blk_minmax #(.M(1), .N(1), .COMPONENTS(3), .COMPONENT_WIDTH(8),
                          .USER_WIDTH(4), .MODE("MAX")) u_one (
    .reset(reset), .clk(clk), .cke(cke),
    .s_img_row_first(rf), .s_img_row_last(rl), .s_img_col_first(cf), .s_img_col_last(cl),
    .s_img_de(de), .s_img_user(user), .s_img_data(d11), .s_img_valid(valid),
    .m_img_row_first(one_fl[5]), .m_img_row_last(one_fl[4]), .m_img_col_first(one_fl[3]),
    .m_img_col_last(one_fl[2]), .m_img_de(one_fl[1]), .m_img_user(one_user),
    .m_img_data(one_data), .m_img_valid(one_fl[0]));

  // One accepted input beat with every configuration's expected result.
  typedef struct {
    logic [5:0]  fl;
    logic [3:0]  user;
    logic [23:0] mx;
    logic [23:0] mn;
    logic [7:0]  col;
    logic [23:0] one;
    bit          zero;
  } beat_t;

  beat_t hist[$];

  function automatic logic [23:0] ref_reduce(input logic [8:0][23:0] w, input int k,
                                             input int comps, input bit is_max);
    logic [23:0] r;
    logic [7:0]  best;
    logic [7:0]  v;
    r = '0;
    for (int c = 0; c < comps; c++) begin
      best = w[0][c*8 +: 8];
      for (int i = 1; i < k; i++) begin
        v = w[i][c*8 +: 8];
        if (is_max ? (v > best) : (v < best)) best = v;
      end
      r[c*8 +: 8] = best;
    end
    return r;
  endfunction

  function automatic beat_t make_beat();
    beat_t            b;
    logic [8:0][23:0] w;
    b.fl   = {rf, rl, cf, cl, de, valid};
    b.user = user;
    w      = d33;
    b.mx   = ref_reduce(w, 9, 3, 1'b1);
    b.mn   = ref_reduce(w, 9, 3, 1'b0);
    w      = '0;
    for (int i = 0; i < 7; i++) w[i] = {16'h0, d17[i][0]};
    b.col  = 8'(ref_reduce(w, 7, 1, 1'b0));
    w      = '0;
    w[0]   = d11[0][0];
    b.one  = ref_reduce(w, 1, 3, 1'b1);
    b.zero = 1'b0;
    return b;
  endfunction

  function automatic beat_t expected(input int lat);
    beat_t b;
    if (hist.size() >= lat) return hist[hist.size() - lat];
    b.fl = '0; b.user = '0; b.mx = '0; b.mn = '0; b.col = '0; b.one = '0; b.zero = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Data is only meaningful on valid+de beats or straight out of reset.
  task automatic compare_all();
    beat_t e;
    e = expected(LAT33);
    check("max_flags", 32'(max_fl), 32'(e.fl));
    check("max_user", 32'(max_user), 32'(e.user));
    if (e.zero || (e.fl[1] && e.fl[0])) check("max_data", 32'(max_data), 32'(e.mx));
    check("min_flags", 32'(min_fl), 32'(e.fl));
    check("min_user", 32'(min_user), 32'(e.user));
    if (e.zero || (e.fl[1] && e.fl[0])) check("min_data", 32'(min_data), 32'(e.mn));
    e = expected(LAT17);
    check("col_flags", 32'(col_fl), 32'(e.fl));
    check("col_user", 32'(col_user), 32'(e.user[0]));
    if (e.zero || (e.fl[1] && e.fl[0])) check("col_data", 32'(col_data), 32'(e.col));
    e = expected(LAT11);
    check("one_flags", 32'(one_fl), 32'(e.fl));
    check("one_user", 32'(one_user), 32'(e.user));
    if (e.zero || (e.fl[1] && e.fl[0])) check("one_data", 32'(one_data), 32'(e.one));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) hist.delete();
    else if (cke) hist.push_back(make_beat());
    #1;
    compare_all();
  endtask

  task automatic drive_random(input int valid_pct);
    {rf, rl, cf, cl} = 4'($urandom);
    de    = ($urandom_range(0, 99) < 80);
    valid = ($urandom_range(0, 99) < valid_pct);
    user  = 4'($urandom);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) d33[y][x] = 24'($urandom);
    for (int i = 0; i < 7; i++) d17[i][0] = 8'($urandom_range(0, 255));
    d11[0][0] = 24'($urandom);
  endtask

  bit cke_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    cke   = 1'b1;
    drive_random(100);
    tick();
    tick();
    check("rst_valid", 32'({max_fl[0], min_fl[0], col_fl[0], one_fl[0]}), 32'h0);
    check("rst_data", {max_data, col_data}, 32'h0);

    reset = 1'b0;
    repeat (5) begin drive_random(0); tick(); end

    // Ramp window: R=1..9, G=9..1, B=5 -> max 9/9, min 1/1.
    drive_random(0);
    valid = 1'b1; de = 1'b1;
    for (int k = 0; k < 9; k++) d33[k/3][k%3] = {8'd5, 8'(9 - k), 8'(k + 1)};
    tick();
    repeat (3) begin drive_random(0); tick(); end
    check("dir1_valid", 32'(max_fl[0]), 32'h1);
    check("dir1_max", 32'(max_data), 32'h050909);
    check("dir1_min", 32'(min_data), 32'h050101);

    // Channels peak at different positions: R 200 @k=1, G 77 @k=6, B flat 5.
    drive_random(0);
    valid = 1'b1; de = 1'b1;
    for (int k = 0; k < 9; k++)
      d33[k/3][k%3] = {8'd5, (k == 6) ? 8'd77 : 8'(k * 3), (k == 1) ? 8'd200 : 8'(10 + k)};
    tick();
    repeat (3) begin drive_random(0); tick(); end
    check("dir2_valid", 32'(max_fl[0]), 32'h1);
    check("dir2_max", 32'(max_data), 32'h054DC8);
    check("dir2_min", 32'(min_data), 32'h05000A);

    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 4; j++) begin
        cke = cke_pat[j];
        drive_random(100);
        tick();
      end
    cke = 1'b1;

    // Reset mid-stream with valid beats in flight.
    repeat (6) begin drive_random(100); tick(); end
    reset = 1'b1;
    drive_random(100);
    tick();
    check("midrst_valid", 32'({max_fl, min_fl, col_fl, one_fl}), 32'h0);
    check("midrst_data", {max_data, col_data}, 32'h0);
    reset = 1'b0;
    repeat (3) begin
      drive_random(100);
      tick();
      check("postrst_valid", 32'(max_fl[0]), 32'h0);
    end

    repeat (400) begin
      cke   = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 49) == 0);
      drive_random(70);
      tick();
    end
    reset = 1'b0;
    cke   = 1'b1;
    repeat (6) begin drive_random(0); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
